// File: rtl/sa_controller_pkg.sv
// ---------------------------------------------------------------------------
// sa_controller_pkg
// Shared definitions for the systolic-array controller:
//   - instruction width and field positions ([4:3] opcode, [2:0] argument)
//   - opcode encodings (WAIT / LOADW / COMPUTE / DRAIN)
//   - controller state encodings
//   - small helpers that pull the opcode and argument out of an instruction
// ---------------------------------------------------------------------------
package sa_controller_pkg;

    localparam int INSTR_W = 5;
    localparam int OP_MSB  = 4;
    localparam int OP_LSB  = 3;
    localparam int ARG_MSB = 2;
    localparam int ARG_LSB = 0;
    localparam int ARG_W   = ARG_MSB - ARG_LSB + 1;

    // The all-zero word marks the end of the program and is never decoded.
    localparam logic [INSTR_W-1:0] INSTR_END = '0;

    typedef enum logic [1:0] {
        OP_WAIT    = 2'b00,
        OP_LOADW   = 2'b01,
        OP_COMPUTE = 2'b10,
        OP_DRAIN   = 2'b11
    } sa_opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_LOADW  = 3'd2,
        ST_CLEAR  = 3'd3,
        ST_STREAM = 3'd4,
        ST_FLUSH  = 3'd5,
        ST_DRAIN  = 3'd6,
        ST_DONE   = 3'd7
    } sa_state_t;

    function automatic sa_opcode_t instr_opcode(input logic [INSTR_W-1:0] instr);
        return sa_opcode_t'(instr[OP_MSB:OP_LSB]);
    endfunction

    function automatic logic [ARG_W-1:0] instr_arg(input logic [INSTR_W-1:0] instr);
        return instr[ARG_MSB:ARG_LSB];
    endfunction

endpackage

// File: rtl/sa_phase_counter.sv
// ---------------------------------------------------------------------------
// sa_phase_counter
// Loadable down-counter shared by every timed phase of the controller.
// A load always wins over a decrement; the counter never wraps below zero.
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous, active-low reset
//   load       in   1   load load_value this cycle
//   load_value in   W   value to load (phase length minus one)
//   enable     in   1   decrement by one this cycle
//   zero       out  1   count is zero (last cycle of the current phase)
// ---------------------------------------------------------------------------
module sa_phase_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sa_controller.sv
// ---------------------------------------------------------------------------
// sa_controller
// Decodes the 5-bit instruction presented by the instruction store and
// sequences the NxN systolic array through weight load, activation streaming
// plus pipeline flush, and result drain. Emits one systolic_array_done pulse
// per completed instruction so the store can advance.
//
// Ports:
//   clk                 in   1      clock, rising edge
//   rst                 in   1      asynchronous, active-low reset
//   instruction         in   5      [4:3] opcode, [2:0] argument
//   ap_done             in   1      program end; blocks the next decode
//   out_ready           in   1      consumer accepts the drained row
//   systolic_array_done out  1      one-cycle pulse per finished instruction
//   w_load / w_row      out  1/IDX_W  weight-load strobe and row index
//   acc_clear           out  1      accumulator clear before streaming
//   a_valid / a_idx     out  1/3    activation beat valid and beat index
//   out_valid / out_row out  1/IDX_W  drained row valid (held) and index
//   busy                out  1      high in every state except IDLE
//
// Optional build macro SA_CTRL_PERF_EN adds:
//   perf_busy_cycles    out  32     saturating count of busy cycles
//   perf_instr_count    out  16     saturating count of done pulses
// ---------------------------------------------------------------------------
module sa_controller
    import sa_controller_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               ap_done,
    input  logic               out_ready,
    output logic               systolic_array_done,
    output logic               w_load,
    output logic [IDX_W-1:0]   w_row,
    output logic               acc_clear,
    output logic               a_valid,
    output logic [2:0]         a_idx,
    output logic               out_valid,
    output logic [IDX_W-1:0]   out_row,
`ifdef SA_CTRL_PERF_EN
    output logic [31:0]        perf_busy_cycles,
    output logic [15:0]        perf_instr_count,
`endif
    output logic               busy
);

    // The phase counter must hold the longest phase (2N-1 flush cycles or
    // 8 stream beats) without wrapping; it is loaded with length minus one.
    localparam int CNT_SPAN = ((2 * N - 1) > 8) ? (2 * N - 1) : 8;
    localparam int CNT_W    = $clog2(CNT_SPAN);

    localparam logic [CNT_W-1:0] ROWS_LAST  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(2 * N - 2);

    sa_state_t        state;
    logic [ARG_W-1:0] arg_q;
    logic             settle;

    logic             decode_ok;
    sa_opcode_t       dec_op;
    logic [ARG_W-1:0] dec_arg;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_value;
    logic             cnt_en;
    logic             cnt_zero;

    assign dec_op  = instr_opcode(instruction);
    assign dec_arg = instr_arg(instruction);

    // settle blocks decode for the one IDLE cycle after DONE, while the
    // store is still presenting the instruction that just finished.
    assign decode_ok = (state == ST_IDLE) && !settle && !ap_done
                       && (instruction != INSTR_END);

    // Counter control: each phase loads its length minus one on entry and
    // counts down; the FSM leaves the phase in the cycle the counter is zero.
    always_comb begin
        cnt_load  = 1'b0;
        cnt_value = '0;
        cnt_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (decode_ok) begin
                    cnt_load = 1'b1;
                    case (dec_op)
                        OP_WAIT:    cnt_value = CNT_W'(dec_arg - ARG_W'(1));
                        OP_COMPUTE: cnt_value = '0;
                        default:    cnt_value = ROWS_LAST;
                    endcase
                end
            end
            ST_WAIT, ST_LOADW, ST_FLUSH: begin
                cnt_en = !cnt_zero;
            end
            ST_CLEAR: begin
                cnt_load  = 1'b1;
                cnt_value = CNT_W'(arg_q);
            end
            ST_STREAM: begin
                if (cnt_zero) begin
                    cnt_load  = 1'b1;
                    cnt_value = FLUSH_LAST;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DRAIN: begin
                // Only an accepted row consumes a count.
                cnt_en = out_ready && !cnt_zero;
            end
            default: begin
                cnt_en = 1'b0;
            end
        endcase
    end

    sa_phase_counter #(
        .W (CNT_W)
    ) u_phase_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (cnt_value),
        .enable     (cnt_en),
        .zero       (cnt_zero)
    );

    // Sequencer: outputs are registered, so each branch sets the strobes
    // that belong to the state being entered. Single-cycle strobes default
    // low every cycle; out_valid and busy are held until explicitly dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state               <= ST_IDLE;
            arg_q               <= '0;
            settle              <= 1'b0;
            systolic_array_done <= 1'b0;
            w_load              <= 1'b0;
            w_row               <= '0;
            acc_clear           <= 1'b0;
            a_valid             <= 1'b0;
            a_idx               <= '0;
            out_valid           <= 1'b0;
            out_row             <= '0;
            busy                <= 1'b0;
        end else begin
            systolic_array_done <= 1'b0;
            w_load              <= 1'b0;
            acc_clear           <= 1'b0;
            a_valid             <= 1'b0;

            case (state)
                ST_IDLE: begin
                    settle <= 1'b0;
                    if (decode_ok) begin
                        arg_q <= dec_arg;
                        busy  <= 1'b1;
                        case (dec_op)
                            OP_WAIT: begin
                                state <= ST_WAIT;
                            end
                            OP_LOADW: begin
                                state  <= ST_LOADW;
                                w_load <= 1'b1;
                                w_row  <= '0;
                            end
                            OP_COMPUTE: begin
                                state     <= ST_CLEAR;
                                acc_clear <= 1'b1;
                            end
                            default: begin
                                state     <= ST_DRAIN;
                                out_valid <= 1'b1;
                                out_row   <= '0;
                            end
                        endcase
                    end
                end

                ST_WAIT: begin
                    if (cnt_zero) begin
                        state               <= ST_DONE;
                        systolic_array_done <= 1'b1;
                    end
                end

                ST_LOADW: begin
                    if (cnt_zero) begin
                        state               <= ST_DONE;
                        systolic_array_done <= 1'b1;
                        w_row               <= '0;
                    end else begin
                        w_load <= 1'b1;
                        w_row  <= w_row + IDX_W'(1);
                    end
                end

                ST_CLEAR: begin
                    state   <= ST_STREAM;
                    a_valid <= 1'b1;
                    a_idx   <= '0;
                end

                ST_STREAM: begin
                    if (cnt_zero) begin
                        state <= ST_FLUSH;
                        a_idx <= '0;
                    end else begin
                        a_valid <= 1'b1;
                        a_idx   <= a_idx + 3'd1;
                    end
                end

                ST_FLUSH: begin
                    if (cnt_zero) begin
                        state               <= ST_DONE;
                        systolic_array_done <= 1'b1;
                    end
                end

                ST_DRAIN: begin
                    if (out_ready) begin
                        if (cnt_zero) begin
                            state               <= ST_DONE;
                            systolic_array_done <= 1'b1;
                            out_valid           <= 1'b0;
                            out_row             <= '0;
                        end else begin
                            out_row <= out_row + IDX_W'(1);
                        end
                    end
                end

                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    settle <= 1'b1;
                end

                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SA_CTRL_PERF_EN
    // Saturating activity counters; they hold at all-ones rather than wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_busy_cycles <= '0;
            perf_instr_count <= '0;
        end else begin
            if (busy && (perf_busy_cycles != '1)) begin
                perf_busy_cycles <= perf_busy_cycles + 32'd1;
            end
            if (systolic_array_done && (perf_instr_count != '1)) begin
                perf_instr_count <= perf_instr_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sa_controller.sv
// ---------------------------------------------------------------------------
// tb_sa_controller
// Self-checking bench for sa_controller (N=4). Directed vector table,
// hand-written multi-cycle sequences (reset, END, ap_done, program run) and
// randomized instructions, all checked against a phase-level reference
// model built from the instruction rules.
// ---------------------------------------------------------------------------
module tb_sa_controller;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] instruction = 5'd0;
    logic       apDone = 1'b0;
    logic       outReady = 1'b0;

    logic       saDone;
    logic       wLoad;
    logic [1:0] wRow;
    logic       accClear;
    logic       aValid;
    logic [2:0] aIdx;
    logic       outValid;
    logic [1:0] outRow;
    logic       busy;
`ifdef SA_CTRL_PERF_EN
    logic [31:0] perfBusyCycles;
    logic [15:0] perfInstrCount;
`endif

    sa_controller #(
        .N     (N),
        .IDX_W (2)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .instruction         (instruction),
        .ap_done             (apDone),
        .out_ready           (outReady),
        .systolic_array_done (saDone),
        .w_load              (wLoad),
        .w_row               (wRow),
        .acc_clear           (accClear),
        .a_valid             (aValid),
        .a_idx               (aIdx),
        .out_valid           (outValid),
        .out_row             (outRow),
`ifdef SA_CTRL_PERF_EN
        .perf_busy_cycles    (perfBusyCycles),
        .perf_instr_count    (perfInstrCount),
`endif
        .busy                (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       done;
        logic       wLoad;
        logic [1:0] wRow;
        logic       accClear;
        logic       aValid;
        logic [2:0] aIdx;
        logic       outValid;
        logic [1:0] outRow;
        logic       busy;
    } outs_t;

    typedef struct {
        logic [4:0] instr;
        int         readyMode;
        int         expLatency;
    } vec_t;

    int    checks = 0;
    int    failures = 0;
    int    donePulses = 0;
    int    expDonePulses = 0;
    int    expBusyCycles = 0;
    outs_t expQ[$];

    // Independent pulse counter: catches doubled or missing done pulses.
    always @(posedge clk) begin
        if (saDone === 1'b1) donePulses++;
    end

    function automatic outs_t sampleOuts();
        outs_t o;
        o.done     = saDone;
        o.wLoad    = wLoad;
        o.wRow     = wRow;
        o.accClear = accClear;
        o.aValid   = aValid;
        o.aIdx     = aIdx;
        o.outValid = outValid;
        o.outRow   = outRow;
        o.busy     = busy;
        return o;
    endfunction

    // Index outputs are only meaningful while their strobe is expected high.
    task automatic checkOutput(input string name, input outs_t exp);
        outs_t act;
        bit    ok;
        act = sampleOuts();
        ok = (act.done === exp.done) && (act.wLoad === exp.wLoad)
             && (act.accClear === exp.accClear) && (act.aValid === exp.aValid)
             && (act.outValid === exp.outValid) && (act.busy === exp.busy)
             && (!exp.wLoad || (act.wRow === exp.wRow))
             && (!exp.aValid || (act.aIdx === exp.aIdx))
             && (!exp.outValid || (act.outRow === exp.outRow));
        checks++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL %s: got done=%b wl=%b wr=%0d clr=%b av=%b ai=%0d ov=%b or=%0d busy=%b, want done=%b wl=%b wr=%0d clr=%b av=%b ai=%0d ov=%b or=%0d busy=%b",
                     name, act.done, act.wLoad, act.wRow, act.accClear, act.aValid, act.aIdx,
                     act.outValid, act.outRow, act.busy, exp.done, exp.wLoad, exp.wRow,
                     exp.accClear, exp.aValid, exp.aIdx, exp.outValid, exp.outRow, exp.busy);
        end
    endtask

    task automatic checkInt(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: expected output per cycle after the decode edge, for
    // every opcode except DRAIN (whose timing depends on out_ready).
    function automatic void buildExpected(input logic [4:0] instr);
        outs_t e;
        int    arg;
        arg = int'(instr[2:0]);
        expQ.delete();
        case (instr[4:3])
            2'b00: begin
                for (int i = 0; i < arg; i++) begin
                    e = '0; e.busy = 1'b1; expQ.push_back(e);
                end
            end
            2'b01: begin
                for (int r = 0; r < N; r++) begin
                    e = '0; e.busy = 1'b1; e.wLoad = 1'b1; e.wRow = 2'(r);
                    expQ.push_back(e);
                end
            end
            default: begin
                e = '0; e.busy = 1'b1; e.accClear = 1'b1; expQ.push_back(e);
                for (int i = 0; i <= arg; i++) begin
                    e = '0; e.busy = 1'b1; e.aValid = 1'b1; e.aIdx = 3'(i);
                    expQ.push_back(e);
                end
                for (int i = 0; i < 2 * N - 1; i++) begin
                    e = '0; e.busy = 1'b1; expQ.push_back(e);
                end
            end
        endcase
        e = '0; e.busy = 1'b1; e.done = 1'b1;
        expQ.push_back(e);
    endfunction

    function automatic logic chooseReady(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return !((k >= 2) && (k <= 4));
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic applyStimulus(input logic [4:0] instr, input logic apd);
        instruction = instr;
        apDone      = apd;
    endtask

    // Runs one instruction from a settled IDLE. Afterwards the finished
    // instruction stays on the bus for two more cycles, as a store with a
    // registered read would present it, and the controller must stay idle.
    task automatic runInstr(input logic [4:0] instr, input int readyMode,
                            input bit scramble, output int latency);
        outs_t e;
        int    cyc;
        applyStimulus(instr, 1'b0);
        tick();
        cyc = 1;
        if (instr[4:3] != 2'b11) begin
            buildExpected(instr);
            for (int i = 0; i < expQ.size(); i++) begin
                if (i > 0) begin
                    tick();
                    cyc++;
                end
                checkOutput($sformatf("instr %b cycle %0d", instr, cyc), expQ[i]);
                if (scramble) applyStimulus(5'($urandom), 1'($urandom_range(0, 1)));
            end
        end else begin
            int row = 0;
            int k = 0;
            while ((row < N) && (k < 200)) begin
                k++;
                e = '0; e.busy = 1'b1; e.outValid = 1'b1; e.outRow = 2'(row);
                checkOutput($sformatf("drain %b cycle %0d", instr, cyc), e);
                outReady = chooseReady(readyMode, k);
                if (scramble) applyStimulus(5'($urandom), 1'($urandom_range(0, 1)));
                tick();
                cyc++;
                if (outReady) row++;
            end
            if (k >= 200) begin
                checks++;
                failures++;
                $display("[TB] FAIL drain timeout: got %0d rows accepted, want %0d", row, N);
            end
            outReady = 1'b0;
            e = '0; e.busy = 1'b1; e.done = 1'b1;
            checkOutput($sformatf("drain %b done", instr), e);
        end
        latency = cyc;
        expDonePulses++;
        expBusyCycles += cyc;
        applyStimulus(instr, 1'b0);
        tick();
        checkOutput($sformatf("settle after %b", instr), '0);
        tick();
        checkOutput($sformatf("no repeat of %b", instr), '0);
        instruction = 5'd0;
    endtask

    vec_t vecs[8];

    initial begin
        int    lat;
        outs_t e;
        logic [4:0] r;

        vecs[0] = '{5'b01000, 0, 5};
        vecs[1] = '{5'b10011, 0, 13};
        vecs[2] = '{5'b11000, 1, 8};
        vecs[3] = '{5'b00101, 0, 6};
        vecs[4] = '{5'b10111, 0, 17};
        vecs[5] = '{5'b11000, 0, 5};
        vecs[6] = '{5'b00001, 0, 2};
        vecs[7] = '{5'b10000, 0, 10};

        // Power-on reset
        #2 rst = 1'b0;
        tick();
        checkOutput("reset asserted", '0);
        tick();
        rst = 1'b1;
        tick();
        checkOutput("idle after reset", '0);

        // Directed vector table
        for (int i = 0; i < 8; i++) begin
            runInstr(vecs[i].instr, vecs[i].readyMode, 1'b0, lat);
            checkInt($sformatf("latency of %b", vecs[i].instr), lat, vecs[i].expLatency);
        end

        // END word and ap_done both hold the controller idle
        applyStimulus(5'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("END word idle", '0);
        end
        applyStimulus(5'b01000, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("ap_done idle", '0);
        end
        runInstr(5'b01000, 0, 1'b0, lat);
        checkInt("latency after ap_done drop", lat, 5);

        // Reset in the middle of STREAM: strobes drop before the next edge
        applyStimulus(5'b10011, 1'b0);
        tick();
        tick();
        tick();
        e = '0; e.busy = 1'b1; e.aValid = 1'b1; e.aIdx = 3'd1;
        checkOutput("stream beat before reset", e);
        #2 rst = 1'b0;
        #1 checkOutput("async reset mid-stream", '0);
        instruction = 5'd0;
        tick();
        rst = 1'b1;
        expBusyCycles = 0;
        expDonePulses = donePulses;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("idle after mid-stream reset", '0);
        end
        checkInt("no done pulse from aborted compute", donePulses, expDonePulses);

        // Program run: LOADW, COMPUTE arg 7, DRAIN, then END with ap_done
        runInstr(5'b01000, 0, 1'b0, lat);
        checkInt("program LOADW latency", lat, 5);
        runInstr(5'b10111, 0, 1'b0, lat);
        checkInt("program COMPUTE latency", lat, 17);
        runInstr(5'b11000, 2, 1'b0, lat);
        applyStimulus(5'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("program end idle", '0);
        end
        checkInt("program done pulses", donePulses, expDonePulses);
`ifdef SA_CTRL_PERF_EN
        checkInt("perf_instr_count after program", perfInstrCount, 3);
        checkInt("perf_busy_cycles after program", perfBusyCycles, expBusyCycles);
`endif

        // Randomized instructions with scrambled bus and ap_done mid-phase
        for (int i = 0; i < 25; i++) begin
            r = 5'($urandom);
            if (r == 5'd0) r = 5'b00001;
            runInstr(r, 2, 1'b1, lat);
        end

        applyStimulus(5'd0, 1'b0);
        tick();
        tick();
        checkInt("total done pulses", donePulses, expDonePulses);
`ifdef SA_CTRL_PERF_EN
        checkInt("perf_instr_count total", perfInstrCount, expDonePulses - (expDonePulses - 28));
        checkInt("perf_busy_cycles total", perfBusyCycles, expBusyCycles);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
